// File: rtl/spi_device.sv
// Mode-0 SPI responder oversampled by the system clock. Host SCK/CS_N/SDI pass through
// 2-flop synchronizers; received bytes pulse out on rx_valid_o, return bytes come from a
// single-entry holding register.
module spi_device (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       spi_sck_i,
  input  logic       spi_cs_ni,
  input  logic       spi_sdi_i,
  output logic       spi_sdo_o,
  output logic       spi_sdo_en_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       tx_underrun_o,
  output logic       busy_o
);

  logic [1:0] sck_sync_q, cs_sync_q, sdi_sync_q;
  logic       sck_hist_q, cs_hist_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  logic cs_active, cs_fall, cs_rise, sck_rise, sck_fall, load, tx_accept;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sck_sync_q <= 2'b00;
      cs_sync_q  <= 2'b11;
      sdi_sync_q <= 2'b11;
      sck_hist_q <= 1'b0;
      cs_hist_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[0], spi_sck_i};
      cs_sync_q  <= {cs_sync_q[0], spi_cs_ni};
      sdi_sync_q <= {sdi_sync_q[0], spi_sdi_i};
      sck_hist_q <= sck_sync_q[1];
      cs_hist_q  <= cs_sync_q[1];
    end
  end

  assign cs_active = ~cs_sync_q[1];
  assign cs_fall   = cs_hist_q & ~cs_sync_q[1];
  assign cs_rise   = ~cs_hist_q & cs_sync_q[1];
  assign sck_rise  = cs_active & sck_sync_q[1] & ~sck_hist_q;
  assign sck_fall  = cs_active & ~sck_sync_q[1] & sck_hist_q;
  // A falling SCK with bit_cnt at 0 follows a completed byte: fetch the next return byte.
  assign load      = cs_fall | (sck_fall & (bit_cnt_q == 3'd0));
  assign tx_accept = tx_valid_i & ~hold_full_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;

    if (cs_rise) begin
      bit_cnt_d  = 3'd0;
      tx_shift_d = 8'hFF;
    end else if (cs_fall) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      rx_shift_d = {rx_shift_q[6:0], sdi_sync_q[1]};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = {rx_shift_q[6:0], sdi_sync_q[1]};
        rx_valid_d = 1'b1;
      end
    end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b1};
    end

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end

    // A full register is never accepted into, so this cannot collide with a reload.
    if (tx_accept) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'hFF;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign spi_sdo_o     = tx_shift_q[7];
  assign spi_sdo_en_o  = cs_active;
  assign busy_o        = cs_active;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_device.sv
// Randomized bench for spi_device: a host model drives frames, a scoreboard checks received
// bytes, and a transaction-level model predicts the bytes the host reads back.
module tb_spi_device;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0, cs_n = 1'b1, sdi = 1'b1;
  logic       sdo, sdo_en, tx_ready, rx_valid, underrun, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_valid = 1'b0;

  int n_cmp = 0, n_bad = 0, und_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] feed_q[$];
  logic [7:0] tx_bytes[4];
  logic [7:0] rx_bytes[4];

  always #5 clk = ~clk;

  spi_device dut (
    .clk_sys_i    (clk),
    .rst_sys_ni   (rst_n),
    .spi_sck_i    (sck),
    .spi_cs_ni    (cs_n),
    .spi_sdi_i    (sdi),
    .spi_sdo_o    (sdo),
    .spi_sdo_en_o (sdo_en),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .tx_underrun_o(underrun),
    .busy_o       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every rx pulse and counts underrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
        else chk("rx_byte", rx_data, exp_rx.pop_front());
      end
      if (underrun) und_cnt++;
    end
  end

  // Feeder: hands queued return bytes to the holding register whenever it is empty.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && feed_q.size() > 0 && tx_ready) begin
        tx_data  = feed_q[0];
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        void'(feed_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held();
    int t = 0;
    while (tx_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("hold_fill", tx_ready, 0);
  endtask

  task automatic check_reset();
    chk("rst_sdo", sdo, 1);
    chk("rst_sdo_en", sdo_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", underrun, 0);
  endtask

  // One host transaction. Every completed byte (and CS fall) fetches one return byte; load j
  // returns the (j-off)-th supplied byte if there is one, else 8'hFF with an underrun.
  task automatic run_frame(input int n, input int abort_bits, input bit late, input int m,
                           input bit pre_held);
    logic [7:0] exp_load[5];
    int loads, off, und_exp, und0, nb, idx;
    logic [7:0] got;
    loads   = (abort_bits > 0) ? 1 : n + 1;
    off     = late ? 1 : 0;
    und_exp = 0;
    for (int j = 0; j < loads; j++) begin
      idx = j - off;
      if (idx >= 0 && idx < m) exp_load[j] = tx_bytes[idx];
      else begin
        exp_load[j] = 8'hFF;
        und_exp++;
      end
    end
    und0 = und_cnt;
    if (!late) begin
      for (int i = (pre_held ? 1 : 0); i < m; i++) feed_q.push_back(tx_bytes[i]);
      if (m > 0 && !pre_held) wait_held();
    end
    cs_n = 1'b0;
    idle(8);
    if (late) for (int i = 0; i < m; i++) feed_q.push_back(tx_bytes[i]);
    for (int k = 0; k < n; k++) begin
      nb = (abort_bits > 0) ? abort_bits : 8;
      if (abort_bits == 0) exp_rx.push_back(rx_bytes[k]);
      got = 8'h00;
      for (int b = 0; b < nb; b++) begin
        sdi = rx_bytes[k][7-b];
        idle($urandom_range(6, 4));
        sck = 1'b1;
        got = {got[6:0], sdo};
        idle($urandom_range(6, 4));
        sck = 1'b0;
      end
      if (abort_bits > 0) begin
        chk("tx_partial", int'(got), int'(exp_load[0]) >> (8 - nb));
        break;
      end
      chk("tx_byte", got, exp_load[k]);
    end
    idle(6);
    cs_n = 1'b1;
    idle(10);
    chk("underruns", und_cnt - und0, und_exp);
    chk("rx_pending", exp_rx.size(), 0);
    chk("tx_ready_end", tx_ready, 1);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, late, m;
    bit en_seen;
    idle(3);
    check_reset();
    rst_n = 1'b1;
    idle(5);

    // Single byte.
    tx_bytes[0] = 8'hA5; rx_bytes[0] = 8'h3C;
    run_frame(1, 0, 0, 1, 0);

    // Back-to-back bytes in one selection.
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h02; tx_bytes[2] = 8'h03;
    for (int i = 0; i < 3; i++) rx_bytes[i] = 8'($urandom);
    run_frame(3, 0, 0, 3, 0);

    // Empty at CS fall; refilled afterwards so only the first load underruns.
    tx_bytes[0] = 8'h99; rx_bytes[0] = 8'hE7;
    run_frame(1, 0, 1, 1, 0);

    // Abort after 5 bits, then a clean frame.
    tx_bytes[0] = 8'hC3; rx_bytes[0] = 8'h96;
    run_frame(1, 5, 0, 1, 0);
    rx_bytes[0] = 8'h5A;
    run_frame(1, 0, 0, 0, 0);

    // SCK activity while deselected must be ignored.
    feed_q.push_back(8'h77);
    wait_held();
    en_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sdi = 1'($urandom);
      repeat (4) begin
        @(negedge clk);
        en_seen |= sdo_en;
      end
      sck = ~sck;
    end
    idle(6);
    chk("en_while_cs_high", en_seen, 0);
    chk("ready_while_cs_high", tx_ready, 0);
    tx_bytes[0] = 8'h77; rx_bytes[0] = 8'h81;
    run_frame(1, 0, 0, 1, 1);

    // Reset mid-frame after 4 bits.
    feed_q.push_back(8'h11);
    wait_held();
    cs_n = 1'b0;
    idle(8);
    for (int b = 0; b < 4; b++) begin
      sdi = 1'($urandom);
      idle(4); sck = 1'b1;
      idle(4); sck = 1'b0;
    end
    rst_n = 1'b0;
    cs_n  = 1'b1;
    idle(2);
    check_reset();
    feed_q.delete();
    rst_n = 1'b1;
    idle(6);
    tx_bytes[0] = 8'h4E; rx_bytes[0] = 8'hB2;
    run_frame(1, 0, 0, 1, 0);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      n    = $urandom_range(3, 1);
      late = $urandom_range(1, 0);
      m    = $urandom_range(n + 1 - late, 0);
      for (int i = 0; i < 4; i++) begin
        tx_bytes[i] = 8'($urandom);
        rx_bytes[i] = 8'($urandom);
      end
      run_frame(n, 0, late[0], m, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
